br_resolve_queue: RTL and testbench
===================================

// Module: br_resolve_queue
// PURPOSE
//  In-order queue of in-flight branch predictions between IF and branch resolve.
//  IF pushes each fetched branch's BTB/BHT metadata. Resolve pops the oldest entry
//  with the actual outcome.
//  Produces the BHT update command (load/clear/br_result/load_set/ways/btb_lru) and a
//  mispredict redirect for fetch.
// PARAMETERS
//  DEPTH   4   queue entries (power of 2, >=2)
//  SET_W   4   BTB/BHT set index width (16 sets)
//  WAY_W   2   way index width (4 ways)
//  PC_W    16  PC width
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, synchronous, active-high
//  push            in   1      IF enqueues one branch this cycle
//  push_hit        in   1      BTB hit at fetch
//  push_way        in   WAY_W  hitting way (valid when push_hit)
//  push_lru        in   WAY_W  BTB LRU way of push_set at fetch
//  push_set        in   SET_W  set index of branch PC
//  push_pred       in   1      predicted taken
//  push_target     in   PC_W   predicted target
//  push_fallthru   in   PC_W   PC+2 of branch
//  full            out  1      queue cannot accept push
//  resolve         in   1      oldest branch resolved this cycle
//  resolve_taken   in   1      actual direction
//  resolve_target  in   PC_W   actual target
//  empty           out  1      no entries
//  count           out  $clog2(DEPTH)+1  occupancy
//  bht_load        out  1      BHT update strobe
//  bht_clear       out  1      new-allocation update (reinit to TT)
//  bht_br_result   out  1      outcome to BHT
//  bht_load_set    out  SET_W  set to update
//  bht_ways        out  WAY_W  hit way to update
//  bht_lru         out  WAY_W  way being allocated
//  mispredict      out  1      one-cycle redirect strobe
//  redirect_pc     out  PC_W   correct fetch PC
//  err             out  1      sticky: resolve while empty
// BEHAVIOUR
//  - Reset: pointers/count 0, empty=1, full=0; all bht_*, mispredict, redirect_pc, err = 0.
//  - Circular buffer, head/tail wrap modulo DEPTH. count is updated the same cycle
//    as push/pop.
//  - full = (count==DEPTH) | mispredict. empty = (count==0). Both are combinational
//    from registered state.
//  - Push while full is ignored: no state change. Upstream must stall.
//  - Resolve while empty is ignored; it sets err, which clears only on rst.
//  - On resolve with head entry E:
//    mp = (E.pred != taken) | (taken & E.pred & E.hit & E.target != resolve_target).
//  - Outputs are registered; all appear in cycle N+1 for resolve in cycle N, for
//    exactly 1 cycle:
//      bht_load  = E.hit | taken   (not-taken misses are not allocated)
//      bht_clear = ~E.hit & taken
//      bht_br_result = taken; bht_load_set = E.set; bht_ways = E.way; bht_lru = E.lru
//      mispredict = mp; redirect_pc = taken ? resolve_target : E.fallthru
//  - When the strobes are not asserted they are 0; the data outputs hold their last value.
//  - Pop on resolve: head++, count--.
//    If mp, all younger entries are wrong-path: flush, count=0, head=tail.
//  - Simultaneous push+resolve, no mp: both occur and count is unchanged. This is
//    legal when full (pop frees the slot), but not in the mispredict cycle.
//  - Simultaneous push+resolve with mp: the push is discarded (wrong path).
//  - Cycle N+1 (mispredict=1): full=1, so any push is rejected. Normal operation
//    resumes at N+2.
//  - rst mid-operation: all entries dropped; no BHT strobe issued for them.
// TESTING
//  1 Reset, then push 4 (DEPTH) entries with no resolve -> full=1, count=4; 5th push
//    ignored, count stays 4.
//  2 Push E{hit=1,way=2,set=5,pred=1,target=0x1234}; resolve taken, target 0x1234 ->
//    next cycle bht_load=1, clear=0, ways=2, set=5, br_result=1, mispredict=0.
//  3 Push E{hit=0,lru=3,set=9,pred=0,fallthru=0x0042}; resolve taken, target 0x0100 ->
//    bht_load=1, clear=1, lru=3, mispredict=1, redirect_pc=0x0100. Next-cycle count=0
//    even with 2 younger entries, and a push in the strobe cycle is rejected.
//  4 Push E{hit=1,pred=1,fallthru=0x0A02}; resolve not taken -> mispredict=1,
//    redirect_pc=0x0A02, br_result=0. Separately, a miss resolved not-taken ->
//    bht_load=0, mispredict=0.
//  5 Full queue, push+resolve same cycle, correct prediction -> count stays 4, order
//    preserved across pointer wrap (verify over 10 wraps vs scoreboard).
//  6 Resolve while empty -> err=1, no strobes. Assert rst with 3 entries -> empty=1,
//    err=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/br_resolve_queue.sv
// rtl/br_resolve_queue.sv - in-order queue of in-flight branch predictions feeding BHT update and fetch redirect
module br_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int SET_W = 4,
  parameter int WAY_W = 2,
  parameter int PC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_hit,
  input  logic [WAY_W-1:0]         push_way,
  input  logic [WAY_W-1:0]         push_lru,
  input  logic [SET_W-1:0]         push_set,
  input  logic                     push_pred,
  input  logic [PC_W-1:0]          push_target,
  input  logic [PC_W-1:0]          push_fallthru,
  output logic                     full,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  input  logic [PC_W-1:0]          resolve_target,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     bht_load,
  output logic                     bht_clear,
  output logic                     bht_br_result,
  output logic [SET_W-1:0]         bht_load_set,
  output logic [WAY_W-1:0]         bht_ways,
  output logic [WAY_W-1:0]         bht_lru,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic [WAY_W-1:0] lru;
    logic [SET_W-1:0] set;
    logic             pred;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  fallthru;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_e;
  entry_t             new_e;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               do_pop;
  logic               do_push;
  logic               mp;
  logic               at_cap;

  assign at_cap = (count == CNT_W'(DEPTH));
  assign full   = at_cap | mispredict;
  assign empty  = (count == '0);
  assign head_e = mem[head];
  assign new_e  = '{hit: push_hit, way: push_way, lru: push_lru, set: push_set,
                    pred: push_pred, target: push_target, fallthru: push_fallthru};

  assign do_pop = resolve & ~empty;
  assign mp     = (head_e.pred != resolve_taken) |
                  (resolve_taken & head_e.pred & head_e.hit & (head_e.target != resolve_target));
  // A pop frees the slot for a same-cycle push, but a mispredicting pop makes the push wrong-path.
  assign do_push = push & ~mispredict & (~at_cap | do_pop) & ~(do_pop & mp);

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= new_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      bht_load      <= 1'b0;
      bht_clear     <= 1'b0;
      bht_br_result <= 1'b0;
      bht_load_set  <= '0;
      bht_ways      <= '0;
      bht_lru       <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      err           <= 1'b0;
    end else begin
      bht_load   <= 1'b0;
      bht_clear  <= 1'b0;
      mispredict <= 1'b0;
      if (resolve & empty) err <= 1'b1;
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop) begin
        bht_load      <= head_e.hit | resolve_taken;
        bht_clear     <= ~head_e.hit & resolve_taken;
        bht_br_result <= resolve_taken;
        bht_load_set  <= head_e.set;
        bht_ways      <= head_e.way;
        bht_lru       <= head_e.lru;
        mispredict    <= mp;
        redirect_pc   <= resolve_taken ? resolve_target : head_e.fallthru;
        if (mp) begin
          head  <= tail;
          count <= '0;
        end else begin
          head <= head + PTR_W'(1);
          if (!do_push) count <= count - CNT_W'(1);
        end
      end else if (do_push) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// tb/tb_br_resolve_queue.sv - directed self-checking bench for br_resolve_queue
module tb_br_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic        push_hit;
  logic [1:0]  push_way;
  logic [1:0]  push_lru;
  logic [3:0]  push_set;
  logic        push_pred;
  logic [15:0] push_target;
  logic [15:0] push_fallthru;
  logic        full;
  logic        resolve;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic        empty;
  logic [2:0]  count;
  logic        bht_load;
  logic        bht_clear;
  logic        bht_br_result;
  logic [3:0]  bht_load_set;
  logic [1:0]  bht_ways;
  logic [1:0]  bht_lru;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  br_resolve_queue dut (
    .clk(clk), .rst(rst),
    .push(push), .push_hit(push_hit), .push_way(push_way), .push_lru(push_lru),
    .push_set(push_set), .push_pred(push_pred), .push_target(push_target),
    .push_fallthru(push_fallthru), .full(full),
    .resolve(resolve), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .empty(empty), .count(count),
    .bht_load(bht_load), .bht_clear(bht_clear), .bht_br_result(bht_br_result),
    .bht_load_set(bht_load_set), .bht_ways(bht_ways), .bht_lru(bht_lru),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 0; push_hit = 0; push_way = 0; push_lru = 0; push_set = 0; push_pred = 0;
    push_target = 0; push_fallthru = 0; resolve = 0; resolve_taken = 0; resolve_target = 0;
  endtask

  task automatic set_push(input logic hit, input logic [1:0] way, input logic [1:0] lru,
                          input logic [3:0] set, input logic pred,
                          input logic [15:0] tgt, input logic [15:0] ft);
    push = 1; push_hit = hit; push_way = way; push_lru = lru; push_set = set;
    push_pred = pred; push_target = tgt; push_fallthru = ft;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset_fill();
    do_reset();
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d err=%b, want 1 0 0 0", empty, full, count, err);
    end
    vectors++;
    if (bht_load !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 16'h0 || bht_load_set !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_outs: load=%b mp=%b redir=%h set=%h, want all 0", bht_load, mispredict, redirect_pc, bht_load_set);
    end
    for (int i = 0; i < 4; i++) begin
      set_push(1'b0, 2'd0, 2'd0, 4'(i), 1'b0, 16'h0, 16'h0);
      tick();
    end
    idle();
    vectors++;
    if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL fill4: full=%b count=%0d empty=%b, want 1 4 0", full, count, empty);
    end
    set_push(1'b0, 2'd0, 2'd0, 4'hF, 1'b0, 16'h0, 16'h0);
    tick();
    idle();
    vectors++;
    if (count !== 3'd4 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL push_when_full: count=%0d full=%b, want 4 1", count, full);
    end
  endtask

  task automatic test_hit_correct();
    do_reset();
    set_push(1'b1, 2'd2, 2'd1, 4'd5, 1'b1, 16'h1234, 16'h0102);
    tick();
    idle();
    resolve = 1; resolve_taken = 1; resolve_target = 16'h1234;
    tick();
    idle();
    vectors++;
    if (bht_load !== 1'b1 || bht_clear !== 1'b0 || bht_ways !== 2'd2 || bht_load_set !== 4'd5 ||
        bht_br_result !== 1'b1 || mispredict !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL hit_correct: load=%b clear=%b ways=%0d set=%0d res=%b mp=%b count=%0d, want 1 0 2 5 1 0 0",
               bht_load, bht_clear, bht_ways, bht_load_set, bht_br_result, mispredict, count);
    end
    tick();
    vectors++;
    if (bht_load !== 1'b0 || bht_load_set !== 4'd5 || bht_br_result !== 1'b1) begin
      miscompares++;
      $display("FAIL strobe_one_cycle: load=%b set=%0d res=%b, want 0 5 1", bht_load, bht_load_set, bht_br_result);
    end
  endtask

  task automatic test_miss_taken_flush();
    do_reset();
    set_push(1'b0, 2'd1, 2'd3, 4'd9, 1'b0, 16'h0000, 16'h0042);
    tick();
    set_push(1'b1, 2'd0, 2'd0, 4'd1, 1'b1, 16'h0500, 16'h0044);
    tick();
    set_push(1'b1, 2'd1, 2'd0, 4'd2, 1'b0, 16'h0600, 16'h0046);
    tick();
    idle();
    set_push(1'b1, 2'd1, 2'd0, 4'd3, 1'b0, 16'h0700, 16'h0048);
    resolve = 1; resolve_taken = 1; resolve_target = 16'h0100;
    tick();
    idle();
    vectors++;
    if (bht_load !== 1'b1 || bht_clear !== 1'b1 || bht_lru !== 2'd3 || bht_load_set !== 4'd9 ||
        mispredict !== 1'b1 || redirect_pc !== 16'h0100) begin
      miscompares++;
      $display("FAIL miss_taken: load=%b clear=%b lru=%0d set=%0d mp=%b redir=%h, want 1 1 3 9 1 0100",
               bht_load, bht_clear, bht_lru, bht_load_set, mispredict, redirect_pc);
    end
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: count=%0d empty=%b full=%b, want 0 1 1", count, empty, full);
    end
    set_push(1'b1, 2'd0, 2'd0, 4'd7, 1'b1, 16'h0800, 16'h0050);
    tick();
    vectors++;
    if (count !== 3'd0 || mispredict !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL push_in_mp_cycle: count=%0d mp=%b full=%b, want 0 0 0", count, mispredict, full);
    end
    tick();
    idle();
    vectors++;
    if (count !== 3'd1) begin
      miscompares++;
      $display("FAIL resume_after_mp: count=%0d, want 1", count);
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    set_push(1'b1, 2'd1, 2'd2, 4'd4, 1'b1, 16'h2000, 16'h0A02);
    tick();
    idle();
    resolve = 1; resolve_taken = 0; resolve_target = 16'h0000;
    tick();
    idle();
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 16'h0A02 || bht_br_result !== 1'b0 ||
        bht_load !== 1'b1 || bht_clear !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_not_taken: mp=%b redir=%h res=%b load=%b clear=%b, want 1 0a02 0 1 0",
               mispredict, redirect_pc, bht_br_result, bht_load, bht_clear);
    end
    tick();
    set_push(1'b0, 2'd0, 2'd1, 4'd6, 1'b0, 16'h0000, 16'h0B02);
    tick();
    idle();
    resolve = 1; resolve_taken = 0;
    tick();
    idle();
    vectors++;
    if (bht_load !== 1'b0 || mispredict !== 1'b0 || bht_clear !== 1'b0 || redirect_pc !== 16'h0B02) begin
      miscompares++;
      $display("FAIL miss_not_taken: load=%b mp=%b clear=%b redir=%h, want 0 0 0 0b02",
               bht_load, mispredict, bht_clear, redirect_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] sb [$];
    logic [3:0] exp_set;
    logic [3:0] s;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = 4'(i * 3);
      set_push(1'b1, s[1:0], 2'd0, s, 1'b0, 16'h0, 16'h0);
      sb.push_back(s);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      s = 4'(k * 7 + 1);
      set_push(1'b1, s[1:0], 2'd0, s, 1'b0, 16'h0, 16'h0);
      resolve = 1; resolve_taken = 0;
      exp_set = sb.pop_front();
      sb.push_back(s);
      tick();
      vectors++;
      if (bht_load !== 1'b1 || bht_load_set !== exp_set || bht_ways !== exp_set[1:0] ||
          count !== 3'd4 || mispredict !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_order[%0d]: load=%b set=%0d ways=%0d count=%0d mp=%b, want 1 %0d %0d 4 0",
                 k, bht_load, bht_load_set, bht_ways, count, mispredict, exp_set, exp_set[1:0]);
      end
    end
    idle();
  endtask

  task automatic test_err_and_reset();
    do_reset();
    resolve = 1; resolve_taken = 1; resolve_target = 16'h3333;
    tick();
    idle();
    vectors++;
    if (err !== 1'b1 || bht_load !== 1'b0 || mispredict !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL resolve_empty: err=%b load=%b mp=%b count=%0d, want 1 0 0 0", err, bht_load, mispredict, count);
    end
    tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: err=%b, want 1", err);
    end
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 2'd3, 2'd2, 4'(8 + i), 1'b1, 16'h4000, 16'h0C00);
      tick();
    end
    idle();
    resolve = 1; resolve_taken = 1; resolve_target = 16'h4000;
    tick();
    idle();
    vectors++;
    if (count !== 3'd3 || redirect_pc !== 16'h4000 || bht_load_set !== 4'd8) begin
      miscompares++;
      $display("FAIL pre_reset: count=%0d redir=%h set=%0d, want 3 4000 8", count, redirect_pc, bht_load_set);
    end
    rst = 1;
    resolve = 1; resolve_taken = 0;
    tick();
    rst = 0;
    idle();
    vectors++;
    if (empty !== 1'b1 || err !== 1'b0 || count !== 3'd0 || bht_load !== 1'b0 || mispredict !== 1'b0 ||
        redirect_pc !== 16'h0 || bht_load_set !== 4'h0 || bht_ways !== 2'd0 || bht_br_result !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: empty=%b err=%b count=%0d load=%b mp=%b redir=%h set=%0d ways=%0d res=%b, want 1 0 0 0 0 0 0 0 0",
               empty, err, count, bht_load, mispredict, redirect_pc, bht_load_set, bht_ways, bht_br_result);
    end
    tick();
    vectors++;
    if (bht_load !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_quiet: load=%b empty=%b, want 0 1", bht_load, empty);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset_fill();
    test_hit_correct();
    test_miss_taken_flush();
    test_not_taken();
    test_back_to_back();
    test_err_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
